clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable integer clock divider with a request/acknowledge interface for
// changing the divide ratio and a graceful start/stop controller.
//
// The divided clock always completes whole periods. A ratio change is applied
// only on a period boundary while running, or immediately when stopped.
// Out-of-range ratios (0 or 1) are rejected and leave the active ratio alone.
//
// Parameters
//   DIV_W    width of the divide-ratio field
//   DEF_DIV  divide ratio loaded at reset (must be >= 2)
//
// Ports
//   clk_in   input   single clock, all flops on its rising edge
//   rst_n    input   asynchronous active-low reset
//   en       input   level: 1 = run the divided clock, 0 = stop it
//   cfg_req  input   new-ratio request, held high until cfg_ack
//   cfg_div  input   requested ratio, sampled when the request is accepted
//   cfg_ack  output  one-cycle pulse: request completed (applied or rejected)
//   cfg_err  output  one-cycle pulse with cfg_ack when the ratio is rejected
//   clk_out  output  divided clock, driven directly from a flop
//   tick     output  pulse in the first clk_in cycle of each clk_out period
//   busy     output  high whenever the controller is not stopped
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_req,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
);

   // Controller states; plain constants keep the encoding visible in waves.
   localparam logic [1:0] ST_STOP     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_STOPPING = 2'd2;

   localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]       state;
   logic [DIV_W-1:0] cnt;       // position inside the current period
   logic [DIV_W-1:0] div;       // active ratio
   logic [DIV_W-1:0] shd;       // ratio captured from the accepted request
   logic             pend;      // a captured request awaits completion
   logic             wait_low;  // request was just completed; wait for cfg_req=0

   // ---------------------------------------------------------------------------
   // Next-state signals
   // ---------------------------------------------------------------------------
   logic [1:0]       state_nxt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] div_nxt;
   logic             clk_out_nxt;
   logic             wait_low_nxt;
   logic             last;      // final cycle of a running period
   logic             shd_ok;    // captured ratio is in range
   logic             apply;     // load the captured ratio at the coming edge
   logic             accept;    // capture a new request at the coming edge

   assign busy   = (state != ST_STOP);
   assign tick   = busy && (cnt == '0);
   assign last   = busy && (cnt == (div - ONE));
   assign shd_ok = (shd >= TWO);

   // A pending request completes at once if it is invalid or the divider is
   // stopped; a valid one on a running divider waits for the period boundary
   // so the current period is never cut short or stretched.
   assign cfg_ack = pend && (!shd_ok || (state == ST_STOP) || last);
   assign cfg_err = cfg_ack && !shd_ok;
   assign apply   = cfg_ack && shd_ok;

   // wait_low blocks a request that is still held high after its cfg_ack from
   // being accepted a second time.
   assign accept = cfg_req && !pend && !cfg_ack && !wait_low;

   assign div_nxt = apply ? shd : div;

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_STOP: begin
            if (en) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            cnt_nxt = last ? '0 : cnt + ONE;
            if (!en) begin
               state_nxt = ST_STOPPING;
            end
         end
         ST_STOPPING: begin
            // Keep counting; stop only once the period has fully completed.
            cnt_nxt = last ? '0 : cnt + ONE;
            if (en) begin
               state_nxt = ST_RUN;
            end else if (last) begin
               state_nxt = ST_STOP;
            end
         end
         default: begin
            state_nxt = ST_STOP;
            cnt_nxt   = '0;
         end
      endcase
   end

   // clk_out is registered from the next-cycle state so it stays glitch-free
   // and already reflects a ratio that is applied at this edge.
   assign clk_out_nxt = (state_nxt != ST_STOP) && (cnt_nxt < (div_nxt >> 1));

   always_comb begin
      wait_low_nxt = wait_low;
      if (cfg_ack) begin
         wait_low_nxt = 1'b1;
      end else if (!cfg_req) begin
         wait_low_nxt = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_STOP;
         cnt      <= '0;
         div      <= DEF_DIV_V;
         shd      <= DEF_DIV_V;
         pend     <= 1'b0;
         wait_low <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         div      <= div_nxt;
         wait_low <= wait_low_nxt;
         clk_out  <= clk_out_nxt;
         if (cfg_ack) begin
            pend <= 1'b0;
         end
         if (accept) begin
            shd  <= cfg_div;
            pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Randomized bench for clk_div_ctrl. A behavioural model (period phase,
// ratio, pending request) predicts the outputs of every cycle; predictions
// are queued by the stimulus process and compared by an independent monitor
// on the falling edge. Expected cfg_err values are queued at acceptance and
// consumed whenever the DUT raises cfg_ack.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int DIV_W   = 8;
   localparam int DEF_DIV = 2;
   localparam int N_CYC   = 4000;

   typedef struct packed {
      logic clk_out;
      logic tick;
      logic busy;
      logic ack;
      logic err;
   } exp_t;

   logic             clk_in = 1'b0;
   logic             rst_n;
   logic             en;
   logic             cfg_req;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ack;
   logic             cfg_err;
   logic             clk_out;
   logic             tick;
   logic             busy;

   clk_div_ctrl #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en),
      .cfg_req (cfg_req),
      .cfg_div (cfg_div),
      .cfg_ack (cfg_ack),
      .cfg_err (cfg_err),
      .clk_out (clk_out),
      .tick    (tick),
      .busy    (busy)
   );

   always #5 clk_in = ~clk_in;

   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   bit   err_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the divider is either idle or inside a period of
   // m_ratio cycles at position m_phase; the first floor(m_ratio/2) cycles
   // of a period are high.
   // ---------------------------------------------------------------------------
   bit m_active, m_stopping, m_pend, m_need_low;
   int m_phase, m_ratio, m_new;

   task automatic model_reset();
      m_active   = 0;
      m_stopping = 0;
      m_pend     = 0;
      m_need_low = 0;
      m_phase    = 0;
      m_ratio    = DEF_DIV;
      m_new      = DEF_DIV;
   endtask

   function automatic bit model_ack();
      bit at_end;
      at_end = m_active && (m_phase == m_ratio - 1);
      return m_pend && ((m_new < 2) || !m_active || at_end);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.clk_out = m_active && (m_phase < m_ratio / 2);
      e.tick    = m_active && (m_phase == 0);
      e.busy    = m_active;
      e.ack     = model_ack();
      e.err     = e.ack && (m_new < 2);
      return e;
   endfunction

   task automatic model_step(input bit e_in, input bit r_in, input int d_in);
      bit at_end, ack, err, acc;
      int nratio;
      at_end = m_active && (m_phase == m_ratio - 1);
      ack    = model_ack();
      err    = ack && (m_new < 2);
      acc    = r_in && !m_pend && !m_need_low;
      nratio = (ack && !err) ? m_new : m_ratio;
      if (!m_active) begin
         if (e_in) begin
            m_active   = 1;
            m_stopping = 0;
            m_phase    = 0;
         end
      end else if (m_stopping && !e_in && at_end) begin
         m_active = 0;
         m_phase  = 0;
      end else begin
         m_phase    = at_end ? 0 : m_phase + 1;
         m_stopping = !e_in;
      end
      m_ratio = nratio;
      if (ack) m_need_low = 1;
      else if (!r_in) m_need_low = 0;
      if (ack) m_pend = 0;
      if (acc) begin
         m_pend = 1;
         m_new  = d_in;
         err_q.push_back(d_in < 2);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares each cycle's outputs against the queued prediction.
   // ---------------------------------------------------------------------------
   always @(negedge clk_in) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL exp_queue: got empty expected an entry at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("clk_out", 32'(clk_out), 32'(e.clk_out));
            check("tick",    32'(tick),    32'(e.tick));
            check("busy",    32'(busy),    32'(e.busy));
            check("cfg_ack", 32'(cfg_ack), 32'(e.ack));
            check("cfg_err", 32'(cfg_err), 32'(e.err));
         end
         if (cfg_ack === 1'b1) begin
            if (err_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_queue: got cfg_ack with no accepted request at %0t", $time);
            end else begin
               bit ee;
               ee = err_q.pop_front();
               check("ack_err", 32'(cfg_err), 32'(ee));
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   function automatic int pick_div();
      if ($urandom_range(7) == 0) return int'($urandom_range(1));
      return 2 + int'($urandom_range(10));
   endfunction

   int  rphase;   // 0 idle, 1 requesting, 2 after acknowledge
   int  n_resets;

   initial begin
      rst_n   = 1'b0;
      en      = 1'b0;
      cfg_req = 1'b0;
      cfg_div = '0;
      rphase  = 0;
      n_resets = 0;
      model_reset();
      #12;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      @(posedge clk_in);
      #1;
      rst_n  = 1'b1;
      en     = 1'b1;
      mon_en = 1'b1;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         exp_t e;

         // Asynchronous reset mid-period while a request is pending.
         if (((cyc > 1500 && n_resets == 0) || (cyc > 3000 && n_resets == 1)) &&
             m_pend && m_active && (m_phase < m_ratio / 2)) begin
            n_resets++;
            mon_en = 1'b0;
            #1;
            rst_n = 1'b0;
            #1;
            check("async_clk_out", 32'(clk_out), 32'd0);
            check("async_busy",    32'(busy),    32'd0);
            check("async_tick",    32'(tick),    32'd0);
            check("async_cfg_ack", 32'(cfg_ack), 32'd0);
            cfg_req = 1'b0;
            rphase  = 0;
            @(negedge clk_in);
            @(posedge clk_in);
            #1;
            rst_n = 1'b1;
            model_reset();
            err_q.delete();
            mon_en = 1'b1;
         end

         if ($urandom_range(11) == 0) en = ~en;

         e = model_out();
         case (rphase)
            0: if ($urandom_range(5) == 0) begin
                  cfg_req = 1'b1;
                  cfg_div = DIV_W'(pick_div());
                  rphase  = 1;
               end
            1: if ($urandom_range(3) == 0) cfg_div = DIV_W'(pick_div());
            default: if ($urandom_range(2) == 0) begin
                  cfg_req = 1'b1;
               end else begin
                  cfg_req = 1'b0;
                  rphase  = 0;
               end
         endcase
         if (rphase == 1 && e.ack) rphase = 2;

         exp_q.push_back(e);
         model_step(en, cfg_req, int'(cfg_div));
         @(posedge clk_in);
         #1;
      end

      mon_en = 1'b0;
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("resets_done",   32'(n_resets),     32'd2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
